seq_array_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle sequencer array. It holds one DRAM row of GROUP_CNT sorted keys, each TGT_BITS wide, and compares them against a target LANES groups per clock, stopping early once the insertion point is found. It produces the group mask, hit flag/index and row-full flag, plus a rewritten row for INSERT (shift up) and DELETE (shift down). It sits between the row buffer and the DRAM write-back path and uses a valid/ready handshake on the command side.

---
 rtl/seq_array_pipe_if.sv | 31 +++
 rtl/seq_array_pipe.sv | 244 ++++++++++++++++++++++++
 tb/tb_seq_array_pipe.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_array_pipe_if.sv
// Command/result bundle between the row-buffer controller and seq_array_pipe.
// The master issues commands; the slave (the sequencer array) returns results.
interface seq_array_pipe_if #(
  parameter int TGT_BITS  = 32,
  parameter int GROUP_CNT = 16
) ();
  localparam int IDX_W = (GROUP_CNT > 1) ? $clog2(GROUP_CNT) : 1;

  logic                          op_valid;
  logic                          op_ready;
  logic [1:0]                    op;
  logic [TGT_BITS-1:0]           target;
  logic [GROUP_CNT*TGT_BITS-1:0] row_i;
  logic [GROUP_CNT*TGT_BITS-1:0] row_o;
  logic                          rslt_valid;
  logic [GROUP_CNT-1:0]          grp_mask;
  logic                          hit;
  logic [IDX_W-1:0]              hit_idx;
  logic                          row_full;
  logic                          err;

  modport master (
    output op_valid, op, target, row_i,
    input  op_ready, row_o, rslt_valid, grp_mask, hit, hit_idx, row_full, err
  );

  modport slave (
    input  op_valid, op, target, row_i,
    output op_ready, row_o, rslt_valid, grp_mask, hit, hit_idx, row_full, err
  );
endinterface

// File: rtl/seq_array_pipe.sv
// Pipelined sorted-row sequencer: scans LANES keys per beat with early stop,
// then reports mask/hit/full and the row rewritten for INSERT or DELETE.
module seq_array_pipe #(
  parameter int TGT_BITS  = 32,
  parameter int GROUP_CNT = 16,
  parameter int LANES     = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  seq_array_pipe_if.slave bus
);
  localparam int NBEATS = GROUP_CNT / LANES;
  localparam int IDX_W  = (GROUP_CNT > 1) ? $clog2(GROUP_CNT) : 1;
  localparam int CNT_W  = IDX_W + 1;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int ROW_W  = GROUP_CNT * TGT_BITS;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_SCAN   = 2'b01;
  localparam logic [1:0] OP_INSERT = 2'b10;
  localparam logic [1:0] OP_DELETE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [GROUP_CNT-1:0] v);
    logic [CNT_W-1:0] n;
    n = {CNT_W{1'b0}};
    for (int i = 0; i < GROUP_CNT; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  state_t               state_r, state_s;
  logic                 ready_r;
  logic [1:0]           op_r;
  logic [TGT_BITS-1:0]  tgt_r;
  logic [ROW_W-1:0]     row_r;
  logic [BEAT_W-1:0]    beat_r;
  logic [GROUP_CNT-1:0] acc_r;
  logic                 hit_r;
  logic [IDX_W-1:0]     hidx_r;

  logic [ROW_W-1:0]     row_o_r;
  logic [GROUP_CNT-1:0] mask_o_r;
  logic                 hit_o_r;
  logic [IDX_W-1:0]     hidx_o_r;
  logic                 full_o_r;
  logic                 err_o_r;
  logic                 rv_r;

  logic [TGT_BITS-1:0]  slot_s [GROUP_CNT];
  logic                 accept_s;
  logic [GROUP_CNT-1:0] beat_mask_s;
  logic                 beat_hit_s;
  logic [IDX_W-1:0]     beat_hidx_s;
  logic                 stop_s;
  logic [GROUP_CNT-1:0] fin_mask_s;
  logic                 fin_hit_s;
  logic [IDX_W-1:0]     fin_hidx_s;
  logic [CNT_W-1:0]     p_s;
  logic                 full_s;
  logic [ROW_W-1:0]     row_up_s;
  logic [ROW_W-1:0]     row_dn_s;
  logic [ROW_W-1:0]     row_res_s;
  logic                 err_res_s;

  for (genvar g = 0; g < GROUP_CNT; g++) begin : g_slot
    assign slot_s[g] = row_r[g*TGT_BITS +: TGT_BITS];
  end

  assign accept_s = (state_r == ST_IDLE) && ready_r && bus.op_valid && (bus.op != OP_NOP);

  // Compare the LANES slots of the current beat and decide whether the scan can stop.
  always_comb begin
    logic [IDX_W-1:0] li_s;
    logic             hit_now_s;
    beat_mask_s = {GROUP_CNT{1'b0}};
    beat_hit_s  = 1'b0;
    beat_hidx_s = {IDX_W{1'b0}};
    stop_s      = (beat_r == BEAT_W'(NBEATS - 1));
    li_s        = {IDX_W{1'b0}};
    hit_now_s   = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      li_s = IDX_W'(int'(beat_r) * LANES + l);
      // An empty slot never hits, even for a zero target.
      hit_now_s   = (slot_s[li_s] != '0) && (slot_s[li_s] == tgt_r) && !beat_hit_s;
      beat_hidx_s = hit_now_s ? li_s : beat_hidx_s;
      beat_hit_s  = beat_hit_s | hit_now_s;
      if (slot_s[li_s] == '0) begin
        stop_s = 1'b1;
      end else if (slot_s[li_s] < tgt_r) begin
        beat_mask_s[li_s] = 1'b1;
      end else begin
        stop_s = 1'b1;
      end
    end
  end

  assign fin_mask_s = acc_r | beat_mask_s;
  assign fin_hit_s  = hit_r | beat_hit_s;
  assign fin_hidx_s = hit_r ? hidx_r : beat_hidx_s;
  assign p_s        = popcount(fin_mask_s);
  assign full_s     = (slot_s[GROUP_CNT-1] != '0);
  assign row_up_s   = {row_r[ROW_W-TGT_BITS-1:0], {TGT_BITS{1'b0}}};
  assign row_dn_s   = {{TGT_BITS{1'b0}}, row_r[ROW_W-1:TGT_BITS]};

  // Build the rewritten row and error flag from the final scan result.
  always_comb begin
    row_res_s = row_r;
    err_res_s = 1'b0;
    case (op_r)
      OP_INSERT: begin
        if (fin_hit_s || full_s || (tgt_r == '0)) begin
          err_res_s = 1'b1;
        end else begin
          for (int g = 0; g < GROUP_CNT; g++) begin
            if (CNT_W'(g) < p_s) begin
              row_res_s[g*TGT_BITS +: TGT_BITS] = slot_s[g];
            end else if (CNT_W'(g) == p_s) begin
              row_res_s[g*TGT_BITS +: TGT_BITS] = tgt_r;
            end else begin
              row_res_s[g*TGT_BITS +: TGT_BITS] = row_up_s[g*TGT_BITS +: TGT_BITS];
            end
          end
        end
      end
      OP_DELETE: begin
        if (!fin_hit_s) begin
          err_res_s = 1'b1;
        end else begin
          for (int g = 0; g < GROUP_CNT; g++) begin
            if (IDX_W'(g) < fin_hidx_s) begin
              row_res_s[g*TGT_BITS +: TGT_BITS] = slot_s[g];
            end else begin
              row_res_s[g*TGT_BITS +: TGT_BITS] = row_dn_s[g*TGT_BITS +: TGT_BITS];
            end
          end
        end
      end
      OP_SCAN: begin
        row_res_s = row_r;
        err_res_s = 1'b0;
      end
      default: begin
        row_res_s = row_r;
        err_res_s = 1'b0;
      end
    endcase
  end

  // Next-state logic for IDLE -> SCAN -> DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_SCAN;
        else          state_s = ST_IDLE;
      end
      ST_SCAN: begin
        if (stop_s) state_s = ST_DONE;
        else        state_s = ST_SCAN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // Ready drops on accept and returns as the DONE cycle ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 ready_r <= 1'b0;
    else if (accept_s)            ready_r <= 1'b0;
    else if (state_r == ST_SCAN)  ready_r <= 1'b0;
    else                          ready_r <= 1'b1;
  end

  // Command capture and per-beat scan accumulators.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r   <= 2'b00;
      tgt_r  <= {TGT_BITS{1'b0}};
      row_r  <= {ROW_W{1'b0}};
      beat_r <= {BEAT_W{1'b0}};
      acc_r  <= {GROUP_CNT{1'b0}};
      hit_r  <= 1'b0;
      hidx_r <= {IDX_W{1'b0}};
    end else if (accept_s) begin
      op_r   <= bus.op;
      tgt_r  <= bus.target;
      row_r  <= bus.row_i;
      beat_r <= {BEAT_W{1'b0}};
      acc_r  <= {GROUP_CNT{1'b0}};
      hit_r  <= 1'b0;
      hidx_r <= {IDX_W{1'b0}};
    end else if (state_r == ST_SCAN) begin
      acc_r  <= fin_mask_s;
      hit_r  <= fin_hit_s;
      hidx_r <= fin_hidx_s;
      beat_r <= stop_s ? beat_r : beat_r + BEAT_W'(1);
    end
  end

  // Result registers load on the final beat so they are valid in the DONE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_o_r  <= {ROW_W{1'b0}};
      mask_o_r <= {GROUP_CNT{1'b0}};
      hit_o_r  <= 1'b0;
      hidx_o_r <= {IDX_W{1'b0}};
      full_o_r <= 1'b0;
      err_o_r  <= 1'b0;
      rv_r     <= 1'b0;
    end else if ((state_r == ST_SCAN) && stop_s) begin
      row_o_r  <= row_res_s;
      mask_o_r <= fin_mask_s;
      hit_o_r  <= fin_hit_s;
      hidx_o_r <= fin_hit_s ? fin_hidx_s : {IDX_W{1'b0}};
      full_o_r <= full_s;
      err_o_r  <= err_res_s;
      rv_r     <= 1'b1;
    end else begin
      rv_r     <= 1'b0;
    end
  end

  assign bus.op_ready   = ready_r;
  assign bus.row_o      = row_o_r;
  assign bus.grp_mask   = mask_o_r;
  assign bus.hit        = hit_o_r;
  assign bus.hit_idx    = hidx_o_r;
  assign bus.row_full   = full_o_r;
  assign bus.err        = err_o_r;
  assign bus.rslt_valid = rv_r;
endmodule

// File: tb/tb_seq_array_pipe.sv
// Bench for seq_array_pipe: queue-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_seq_array_pipe;
  localparam int TB = 16;
  localparam int GC = 8;
  localparam int LN = 2;
  localparam int NB = GC / LN;

  logic clk = 1'b0;
  logic reset_n;

  seq_array_pipe_if #(.TGT_BITS(TB), .GROUP_CNT(GC)) bus ();

  seq_array_pipe #(.TGT_BITS(TB), .GROUP_CNT(GC), .LANES(LN)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [127:0] r;
    r = {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    return r;
  endfunction

  // Reference: result of one command computed straight from the row rules.
  task automatic model(input logic [1:0] op, input logic [15:0] tgt, input logic [127:0] row,
                       output logic [127:0] r_o, output logic [7:0] m, output logic h,
                       output logic [2:0] hi, output logic f, output logic e, output int k);
    int keys[$];
    int first_stop;
    keys = {};
    for (int g = 0; g < GC; g++) keys.push_back(int'(row[g*16 +: 16]));
    m = 8'h00; h = 1'b0; hi = 3'd0; e = 1'b0; k = NB; first_stop = -1;
    for (int g = 0; g < GC; g++) begin
      if (keys[g] != 0 && keys[g] < int'(tgt)) m[g] = 1'b1;
      else if (first_stop < 0) first_stop = g;
    end
    if (first_stop >= 0) k = first_stop / LN + 1;
    for (int g = 0; g < GC; g++) begin
      if (!h && keys[g] != 0 && keys[g] == int'(tgt)) begin
        h = 1'b1;
        hi = 3'(g);
      end
    end
    f = (keys[GC-1] != 0);
    r_o = row;
    if (op == 2'b10) begin
      if (h || f || tgt == 16'd0) e = 1'b1;
      else begin
        keys.insert($countones(m), int'(tgt));
        void'(keys.pop_back());
        for (int g = 0; g < GC; g++) r_o[g*16 +: 16] = 16'(keys[g]);
      end
    end else if (op == 2'b11) begin
      if (!h) e = 1'b1;
      else begin
        keys.delete(int'(hi));
        keys.push_back(0);
        for (int g = 0; g < GC; g++) r_o[g*16 +: 16] = 16'(keys[g]);
      end
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic armed;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) armed <= 1'b0;
    else          armed <= 1'b1;
  end

  // Pending command and held expectations.
  bit           pending = 1'b0;
  int           acc_edge, due_edge, last_acc_edge;
  logic [127:0] p_row, h_row;
  logic [7:0]   p_mask, h_mask;
  logic         p_hit, p_full, p_err, h_hit, h_full, h_err;
  logic [2:0]   p_idx, h_idx;
  int           p_k;
  int           acc_cnt = 0, done_cnt = 0, rv_cnt = 0, rv_cyc = 0;
  logic [127:0] last_row;
  logic [7:0]   last_mask;
  logic         last_hit, last_full, last_err;
  logic [2:0]   last_idx;

  initial begin
    h_row = '0; h_mask = '0; h_hit = 1'b0; h_idx = '0; h_full = 1'b0; h_err = 1'b0;
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    bit busy, exp_ready, exp_rv;
    if (!reset_n) begin
      pending = 1'b0;
      h_row = '0; h_mask = '0; h_hit = 1'b0; h_idx = '0; h_full = 1'b0; h_err = 1'b0;
      chk("rst_rslt_valid", bus.rslt_valid, 1'b0);
    end else begin
      busy      = pending && cyc >= acc_edge && cyc <= due_edge;
      exp_ready = armed && !busy;
      exp_rv    = pending && cyc == due_edge;
      chk("op_ready", bus.op_ready, exp_ready);
      chk("rslt_valid", bus.rslt_valid, exp_rv);
      if (exp_rv) begin
        h_row = p_row; h_mask = p_mask; h_hit = p_hit; h_idx = p_idx;
        h_full = p_full; h_err = p_err;
        pending = 1'b0;
        done_cnt++;
      end
      if (bus.rslt_valid) begin
        last_row = bus.row_o; last_mask = bus.grp_mask; last_hit = bus.hit;
        last_idx = bus.hit_idx; last_full = bus.row_full; last_err = bus.err;
        rv_cnt++;
        rv_cyc = cyc;
      end
      if (!pending && bus.op_valid && exp_ready && bus.op != 2'b00) begin
        model(bus.op, bus.target, bus.row_i, p_row, p_mask, p_hit, p_idx, p_full, p_err, p_k);
        acc_edge = cyc + 1;
        last_acc_edge = acc_edge;
        due_edge = cyc + 1 + p_k;
        pending = 1'b1;
        acc_cnt++;
      end
    end
    chk("row_o", bus.row_o, h_row);
    chk("grp_mask", bus.grp_mask, h_mask);
    chk("hit", bus.hit, h_hit);
    chk("hit_idx", bus.hit_idx, h_idx);
    chk("row_full", bus.row_full, h_full);
    chk("err", bus.err, h_err);
  end

  task automatic run_op(input logic [1:0] op, input int tgt, input logic [127:0] row);
    int a0, d0;
    bit got;
    @(posedge clk); #1;
    a0 = acc_cnt; d0 = done_cnt;
    bus.op_valid = 1'b1; bus.op = op; bus.target = 16'(tgt); bus.row_i = row;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      got = (acc_cnt != a0);
    end
    #1;
    bus.op_valid = 1'b0; bus.target = 16'hFFFF; bus.row_i = {128{1'b1}};
    chk("accept_wait", got, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      got = (done_cnt != d0);
    end
    chk("result_wait", got, 1'b1);
  endtask

  function automatic int lat();
    return rv_cyc - last_acc_edge + 1;
  endfunction

  logic [127:0] r1, rf;

  initial begin
    int a0, r0;
    bit got;
    r1 = pk(3, 7, 9, 20, 0, 0, 0, 0);
    rf = pk(1, 2, 3, 4, 5, 6, 7, 8);
    bus.op_valid = 1'b0; bus.op = 2'b00; bus.target = '0; bus.row_i = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", bus.op_ready, 1'b1);

    run_op(2'b01, 9, r1);
    chk("scan9_latency", lat(), 3);
    chk("scan9_mask", last_mask, 8'b00000011);
    chk("scan9_hit", last_hit, 1'b1);
    chk("scan9_idx", last_idx, 3'd2);
    chk("scan9_err", last_err, 1'b0);
    chk("scan9_row", last_row, r1);

    run_op(2'b10, 8, r1);
    chk("ins8_row", last_row, pk(3, 7, 8, 9, 20, 0, 0, 0));
    chk("ins8_mask", last_mask, 8'b00000011);
    chk("ins8_hit", last_hit, 1'b0);
    chk("ins8_err", last_err, 1'b0);
    chk("ins8_full", last_full, 1'b0);

    run_op(2'b10, 10, rf);
    chk("insfull_latency", lat(), 5);
    chk("insfull_mask", last_mask, 8'hFF);
    chk("insfull_full", last_full, 1'b1);
    chk("insfull_err", last_err, 1'b1);
    chk("insfull_row", last_row, rf);

    run_op(2'b11, 7, r1);
    chk("del7_row", last_row, pk(3, 9, 20, 0, 0, 0, 0, 0));
    chk("del7_idx", last_idx, 3'd1);
    chk("del7_err", last_err, 1'b0);

    run_op(2'b11, 5, r1);
    chk("del5_hit", last_hit, 1'b0);
    chk("del5_err", last_err, 1'b1);
    chk("del5_row", last_row, r1);
    chk("del5_mask", last_mask, 8'b00000001);

    run_op(2'b10, 0, r1);
    chk("ins0_err", last_err, 1'b1);
    chk("ins0_row", last_row, r1);

    // NOP is consumed silently.
    r0 = rv_cnt;
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op = 2'b00; bus.target = 16'd9; bus.row_i = r1;
    repeat (4) @(posedge clk);
    #1 bus.op_valid = 1'b0;
    repeat (2) @(posedge clk);
    chk("nop_no_result", rv_cnt - r0, 0);

    // op_valid held across several scans: one accept per result.
    r0 = rv_cnt; a0 = acc_cnt;
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op = 2'b01; bus.target = 16'd9; bus.row_i = r1;
    repeat (12) @(posedge clk);
    #1 bus.op_valid = 1'b0;
    for (int i = 0; i < 20 && pending; i++) @(posedge clk);
    @(posedge clk);
    chk("hold_result_count", rv_cnt - r0, 3);
    chk("hold_accept_vs_result", rv_cnt - r0, acc_cnt - a0);

    // Reset during beat 1 aborts the command.
    r0 = rv_cnt; a0 = acc_cnt;
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op = 2'b01; bus.target = 16'd9; bus.row_i = r1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      got = (acc_cnt != a0);
    end
    #1 bus.op_valid = 1'b0;
    chk("rst_accept_wait", got, 1'b1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_row_o", bus.row_o, 128'd0);
    chk("rst_mid_mask", bus.grp_mask, 8'd0);
    chk("rst_mid_err", bus.err, 1'b0);
    chk("rst_mid_full", bus.row_full, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready_after", bus.op_ready, 1'b1);
    repeat (6) @(posedge clk);
    chk("rst_mid_no_result", rv_cnt - r0, 0);

    run_op(2'b10, 25, r1);
    chk("ins25_latency", lat(), 4);
    chk("ins25_row", last_row, pk(3, 7, 9, 20, 25, 0, 0, 0));
    chk("ins25_mask", last_mask, 8'b00001111);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
